bin2bcd_seq: RTL and testbench

Sequential double-dabble converter: turns a 20-bit binary count into six packed BCD digits over BIN_W clock cycles, using shift-and-add-3 instead of a wide combinational adder chain. Sits between the 0.01 s display counter and the segment scan controller on the dynamic seven-segment path. Start/busy/done handshake; result and overflow flag held stable between conversions so the scanner always reads a coherent value.

---
 rtl/bin2bcd_seq_pkg.sv | 9 +
 rtl/bin2bcd_seq_digit_adj.sv | 9 +
 rtl/bin2bcd_seq.sv | 70 +++++++
 tb/tb_bin2bcd_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// bin2bcd_seq_pkg: shared widths, FSM encoding and digit constants for the sequential BCD converter
package bin2bcd_seq_pkg;
  localparam int DEF_BIN_W = 20;
  localparam int DEF_DIGITS = 6;
  localparam int BCD_W = 4 * DEF_DIGITS;
  localparam logic [3:0] DIG_GE = 4'd5;
  localparam logic [3:0] DIG_ADD = 4'd3;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 to any digit of 5 or more
module bcd_digit_adj
  import bin2bcd_seq_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= DIG_GE) ? d + DIG_ADD : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: serial shift-and-add-3 binary to packed BCD converter, one bit per cycle
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W = DEF_BIN_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);
  localparam int SCR_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);
  state_t st;
  logic [BIN_W-1:0] sh;
  logic [SCR_W-1:0] scr, adj, scr_n;
  logic [CNT_W-1:0] cnt;
  logic sticky, carry;
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (.d(scr[4*g +: 4]), .q(adj[4*g +: 4]));
  end
  // the bit pushed out of the top digit is a dropped decimal carry, i.e. overflow
  assign scr_n = {adj[SCR_W-2:0], sh[BIN_W-1]};
  assign carry = adj[SCR_W-1];
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      st <= IDLE;
      sh <= '0;
      scr <= '0;
      cnt <= '0;
      sticky <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      bcd_out <= '0;
      ovf <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          sh <= bin_in;
          scr <= '0;
          sticky <= 1'b0;
          cnt <= '0;
          busy <= 1'b1;
          st <= SHIFT;
        end
        SHIFT: begin
          sh <= {sh[BIN_W-2:0], 1'b0};
          scr <= scr_n;
          sticky <= sticky | carry;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(BIN_W - 1)) begin
            bcd_out <= scr_n;
            ovf <= sticky | carry;
            done <= 1'b1;
            busy <= 1'b0;
            cnt <= '0;
            st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq, expected values from an arithmetic decimal model
module tb_bin2bcd_seq;
  logic sys_clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [19:0] bin_in = '0;
  logic busy, done, ovf;
  logic [23:0] bcd_out;
  logic [24:0] sb[$];
  logic [24:0] exp_v;
  int checks = 0, failures = 0;

  bin2bcd_seq dut (.sys_clk(sys_clk), .rst(rst), .start(start), .bin_in(bin_in),
                   .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf));

  always #5 sys_clk = ~sys_clk;

  function automatic logic [24:0] model(input int v);
    logic [23:0] r = '0;
    int m = v % 1000000;
    for (int d = 0; d < 6; d++) begin
      r[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {r, v >= 1000000};
  endfunction

  // waits for done from the negedge after the accept edge; lat counts edges, busy_bad counts busy-low cycles
  task automatic wait_done(output int lat, output int busy_bad);
    lat = 0;
    busy_bad = 0;
    while (!done && lat < 40) begin
      if (!busy) busy_bad++;
      @(negedge sys_clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    @(negedge sys_clk);
    @(negedge sys_clk);
    checks += 4;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    if (bcd_out !== 24'h0) begin failures++; $display("FAIL reset_bcd got=%h exp=000000", bcd_out); end
    if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    rst = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic test_convert;
    int vals[5] = '{0, 999999, 123456, 1048575, 5};
    int lat, bb;
    foreach (vals[i]) begin
      start = 1'b1;
      bin_in = 20'(vals[i]);
      sb.push_back(model(vals[i]));
      @(negedge sys_clk);
      start = 1'b0;
      bin_in = 20'h55555;
      wait_done(lat, bb);
      exp_v = sb.pop_front();
      checks += 5;
      if (lat !== 20) begin failures++; $display("FAIL conv_latency v=%0d got=%0d exp=20", vals[i], lat); end
      if (bb !== 0) begin failures++; $display("FAIL conv_busy v=%0d busy_low_cycles=%0d exp=0", vals[i], bb); end
      if (busy !== 1'b0) begin failures++; $display("FAIL conv_busy_at_done v=%0d got=%b exp=0", vals[i], busy); end
      if ({bcd_out, ovf} !== exp_v) begin
        failures++;
        $display("FAIL conv_result v=%0d got=%h/%b exp=%h/%b", vals[i], bcd_out, ovf, exp_v[24:1], exp_v[0]);
      end
      @(negedge sys_clk);
      if (done !== 1'b0 || {bcd_out, ovf} !== exp_v) begin
        failures++;
        $display("FAIL conv_hold v=%0d done=%b got=%h/%b exp=%h/%b", vals[i], done, bcd_out, ovf, exp_v[24:1], exp_v[0]);
      end
    end
  endtask

  task automatic test_start_ignored;
    int lat = 0, bb = 0, extra = 0;
    start = 1'b1;
    bin_in = 20'd42;
    sb.push_back(model(42));
    @(negedge sys_clk);
    start = 1'b0;
    repeat (4) begin
      @(negedge sys_clk);
      lat++;
    end
    start = 1'b1;
    bin_in = 20'd77;
    @(negedge sys_clk);
    lat++;
    start = 1'b0;
    bin_in = 20'd99;
    while (!done && lat < 40) begin
      if (!busy) bb++;
      @(negedge sys_clk);
      lat++;
    end
    exp_v = sb.pop_front();
    checks += 4;
    if (lat !== 20) begin failures++; $display("FAIL ign_latency got=%0d exp=20", lat); end
    if (bb !== 0) begin failures++; $display("FAIL ign_busy busy_low_cycles=%0d exp=0", bb); end
    if ({bcd_out, ovf} !== exp_v) begin
      failures++;
      $display("FAIL ign_result got=%h/%b exp=%h/%b", bcd_out, ovf, exp_v[24:1], exp_v[0]);
    end
    repeat (30) begin
      @(negedge sys_clk);
      if (done || busy) extra++;
    end
    if (extra !== 0) begin failures++; $display("FAIL ign_extra_activity got=%0d exp=0", extra); end
  endtask

  task automatic test_back_to_back;
    int vals[4] = '{10, 11, 10, 11};
    int lat, bb;
    start = 1'b1;
    bin_in = 20'(vals[0]);
    sb.push_back(model(vals[0]));
    foreach (vals[i]) begin
      @(negedge sys_clk);
      if (i + 1 < 4) begin
        bin_in = 20'(vals[i+1]);
        sb.push_back(model(vals[i+1]));
      end else start = 1'b0;
      wait_done(lat, bb);
      exp_v = sb.pop_front();
      checks += 3;
      if (lat !== 20) begin failures++; $display("FAIL b2b_latency idx=%0d got=%0d exp=20", i, lat); end
      if (bb !== 0) begin failures++; $display("FAIL b2b_busy idx=%0d busy_low_cycles=%0d exp=0", i, bb); end
      if ({bcd_out, ovf} !== exp_v) begin
        failures++;
        $display("FAIL b2b_result idx=%0d got=%h/%b exp=%h/%b", i, bcd_out, ovf, exp_v[24:1], exp_v[0]);
      end
    end
    @(negedge sys_clk);
  endtask

  task automatic test_reset_abort;
    int lat, bb, seen = 0;
    start = 1'b1;
    bin_in = 20'd999999;
    sb.push_back(model(999999));
    @(negedge sys_clk);
    start = 1'b0;
    repeat (10) @(negedge sys_clk);
    rst = 1'b1;
    void'(sb.pop_back());
    @(negedge sys_clk);
    rst = 1'b0;
    checks += 5;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
    if (bcd_out !== 24'h0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL abort_clear got=%h/%b exp=000000/0", bcd_out, ovf);
    end
    repeat (30) begin
      @(negedge sys_clk);
      if (done) seen++;
    end
    if (seen !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    start = 1'b1;
    bin_in = 20'd7;
    sb.push_back(model(7));
    @(negedge sys_clk);
    start = 1'b0;
    wait_done(lat, bb);
    exp_v = sb.pop_front();
    if (lat !== 20 || {bcd_out, ovf} !== exp_v) begin
      failures++;
      $display("FAIL abort_next lat=%0d got=%h/%b exp=20 %h/%b", lat, bcd_out, ovf, exp_v[24:1], exp_v[0]);
    end
  endtask

  initial begin
    test_reset;
    test_convert;
    test_start_ignored;
    test_back_to_back;
    test_reset_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
